mul_fp6: RTL and testbench
==========================

// Module: mul_fp6
// PURPOSE
//  Registered exact multiplier for a small minifloat format (default E5M2, 8-bit code).
//  Decodes both operands and forms the exact signed fixed-point product, with no rounding.
//  Result LSB = product of two smallest subnormals (min_sub^2), i.e. o_prd = v0*v1/min_sub^2.
//  Sits ahead of MX dot-product accumulators, which sum the wide integer products directly.
// PARAMETERS
//  exp_width  5  exponent field bits
//  man_width  2  mantissa field bits
//  (derived) bit_width = 1+exp_width+man_width; prd_width = 2*((1<<exp_width)+man_width+2)
// PORTS
//  clk    in   1          clock, rising edge
//  rst    in   1          synchronous, active-high reset
//  i_vld  in   1          operands valid this cycle
//  i_op0  in   bit_width  operand 0 {sign, exp, man}
//  i_op1  in   bit_width  operand 1 {sign, exp, man}
//  o_vld  out  1          o_prd valid
//  o_prd  out  prd_width  signed two's-complement product, LSB = min_sub^2
// BEHAVIOUR
//  Decode (per operand):
//  - S = op[msb]; E = exp field; M = man field.
//  - Significand sig = {E!=0, M}, man_width+1 bits unsigned.
//  - Scale sh = (E==0) ? 0 : E-1.
//  - Value = sig * 2^sh in units of min_sub.
//  - No inf/NaN: all-ones exponent is an ordinary normal binade.
//  Product:
//  - mag = (sig0*sig1) << (sh0+sh1). Exact; max 49*2^60 at default, which fits prd_width.
//  - o_prd = (S0^S1) ? -mag : mag.
//  - A zero magnitude always yields 0; no negative zero.
//  Timing:
//  - Latency 1 cycle. On rising clk, o_prd <= f(i_op0, i_op1) and o_vld <= i_vld.
//  - o_prd updates every cycle regardless of i_vld. o_vld only qualifies the result.
//  - Full throughput: a new operand pair may be presented every cycle; no backpressure.
//  Reset:
//  - rst=1 at a clock edge sets o_prd=0 and o_vld=0.
//  - rst has priority over any operand presented in the same cycle; that operation is dropped.
//  - The first result after rst deasserts comes from operands sampled at the first edge with rst=0.
//  Width rules:
//  - Operands are raw bit patterns; they are not sign-extended before decode.
//  - The shift is performed at full prd_width; no truncation or saturation anywhere.
// TESTING (defaults E5M2; codes in hex)
//  - 01*01 -> 1; 01*81 -> -1 (min subnormal squared, sign xor).
//  - 04*04 -> 16 (min normal: sig=4, sh=0); 05*06 -> 30.
//  - 80*05 -> 0, and 00*FF -> 0 (signed zeros give 0, never a negative value).
//  - 7F*7F -> 49*2^60; FF*7F -> -(49*2^60) (max magnitude, no overflow).
//  - Exhaustive 65536 pairs, i_vld=1 every cycle. o_prd, one cycle after inputs, must equal
//    the real-valued model v(a)*v(b)/v(01)^2, where v(c) = (-1)^S * ((E?1:0)+M/4) * 2^max(E,1).
//  - Assert rst mid-stream -> o_prd=0 and o_vld=0 on the next edge.
//    The pair presented during reset is not output; the stream resumes one cycle after release.

Source files
------------

// File: rtl/mul_fp6.sv
// mul_fp6: one-cycle exact multiplier for an E<exp_width>M<man_width> minifloat.
// Both operands are decoded to an integer significand and a binary scale in
// units of the smallest subnormal. The product is formed without rounding as a
// signed two's-complement integer whose LSB is min_sub^2, so downstream
// accumulators can add products directly. There is no inf/NaN encoding: the
// all-ones exponent is an ordinary normal binade.
module mul_fp6 #(
  parameter int exp_width = 5,
  parameter int man_width = 2,
  localparam int bit_width = 1 + exp_width + man_width,
  localparam int prd_width = 2 * ((1 << exp_width) + man_width + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  input  logic [bit_width-1:0] i_op0,
  input  logic [bit_width-1:0] i_op1,
  output logic                 o_vld,
  output logic [prd_width-1:0] o_prd
);

  localparam int sig_width = man_width + 1;
  localparam int sh_width  = exp_width;
  localparam int ssum_width = exp_width + 1;
  localparam int psig_width = 2 * sig_width;

  // Significand with the implicit leading one restored for normal codes.
  function automatic logic [sig_width-1:0] dec_sig(input logic [bit_width-1:0] op);
    logic [exp_width-1:0] e;
    logic [man_width-1:0] m;
    e = op[bit_width-2:man_width];
    m = op[man_width-1:0];
    return {(e != {exp_width{1'b0}}), m};
  endfunction

  // Binary scale of the significand: subnormals and the first normal binade
  // share scale 0, each later binade doubles it.
  function automatic logic [sh_width-1:0] dec_sh(input logic [bit_width-1:0] op);
    logic [exp_width-1:0] e;
    logic [sh_width-1:0]  sh;
    e = op[bit_width-2:man_width];
    if (e == {exp_width{1'b0}}) begin
      sh = {sh_width{1'b0}};
    end else begin
      sh = e - {{(exp_width-1){1'b0}}, 1'b1};
    end
    return sh;
  endfunction

  logic [sig_width-1:0]  sig0_s;
  logic [sig_width-1:0]  sig1_s;
  logic [sh_width-1:0]   sh0_s;
  logic [sh_width-1:0]   sh1_s;
  logic [ssum_width-1:0] sh_sum_s;
  logic [psig_width-1:0] psig_s;
  logic [prd_width-1:0]  mag_s;
  logic                  neg_s;

  logic [prd_width-1:0]  prd_d;
  logic [prd_width-1:0]  prd_q;
  logic                  vld_d;
  logic                  vld_q;

  // Decode both operands and form the exact signed product.
  always_comb begin
    sig0_s   = dec_sig(i_op0);
    sig1_s   = dec_sig(i_op1);
    sh0_s    = dec_sh(i_op0);
    sh1_s    = dec_sh(i_op1);
    sh_sum_s = {1'b0, sh0_s} + {1'b0, sh1_s};
    psig_s   = sig0_s * sig1_s;
    // The shift is done at full product width; the largest magnitude still
    // leaves headroom for the sign bit, so nothing is ever truncated.
    mag_s    = {{(prd_width-psig_width){1'b0}}, psig_s} << sh_sum_s;
    neg_s    = i_op0[bit_width-1] ^ i_op1[bit_width-1];
    // Negating a zero magnitude yields zero, so signed zeros never produce -0.
    if (neg_s) begin
      prd_d = {prd_width{1'b0}} - mag_s;
    end else begin
      prd_d = mag_s;
    end
    vld_d = i_vld;
  end

  // Result register: the product updates every cycle, valid only qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      prd_q <= {prd_width{1'b0}};
      vld_q <= 1'b0;
    end else begin
      prd_q <= prd_d;
      vld_q <= vld_d;
    end
  end

  assign o_prd = prd_q;
  assign o_vld = vld_q;

endmodule

// File: tb/tb_mul_fp6.sv
// tb_mul_fp6: directed and exhaustive check of mul_fp6 at the default E5M2 format.
module tb_mul_fp6;

  localparam int BW = 8;
  localparam int PW = 72;

  logic          clk;
  logic          rst;
  logic          i_vld;
  logic [BW-1:0] i_op0;
  logic [BW-1:0] i_op1;
  logic          o_vld;
  logic [PW-1:0] o_prd;

  int n_vec;
  int n_err;

  mul_fp6 dut (
    .clk   (clk),
    .rst   (rst),
    .i_vld (i_vld),
    .i_op0 (i_op0),
    .i_op1 (i_op1),
    .o_vld (o_vld),
    .o_prd (o_prd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Real-valued rule scaled by 4 so everything stays integral:
  // 4*v(c) = ((E?4:0)+M) * 2^max(E,1) * sign, and 4*v(01) = 2,
  // hence product = (4v(a))*(4v(b)) / 4.
  function automatic logic signed [PW-1:0] qval(input logic [BW-1:0] c);
    int e;
    int m;
    int s;
    logic signed [PW-1:0] q;
    e = int'(c[6:2]);
    m = int'(c[1:0]);
    s = ((e != 0) ? 4 : 0) + m;
    q = PW'(s) * (72'sd1 <<< ((e > 1) ? e : 1));
    if (c[7]) q = -q;
    return q;
  endfunction

  function automatic logic signed [PW-1:0] model(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic signed [PW-1:0] p;
    p = qval(a) * qval(b);
    return p / 72'sd4;
  endfunction

  // Expected outputs one cycle after the inputs, tracked from the stimulus.
  logic signed [PW-1:0] exp_prd;
  logic                 exp_vld;
  logic                 started;
  initial started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_prd <= '0;
      exp_vld <= 1'b0;
    end else begin
      exp_prd <= model(i_op0, i_op1);
      exp_vld <= i_vld;
    end
    started <= 1'b1;
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      n_vec = n_vec + 1;
      if (o_prd !== exp_prd || o_vld !== exp_vld) begin
        n_err = n_err + 1;
        $display("FAIL stream t=%0t prd got %0d want %0d, vld got %0b want %0b",
                 $time, $signed(o_prd), exp_prd, o_vld, exp_vld);
      end
    end
  end

  task automatic pin_model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input logic signed [PW-1:0] want, input string name);
    logic signed [PW-1:0] got;
    got = model(a, b);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL model_%s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic apply_chk(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic v,
                           input logic signed [PW-1:0] want, input string name);
    @(negedge clk);
    i_op0 = a;
    i_op1 = b;
    i_vld = v;
    @(posedge clk);
    #1;
    n_vec = n_vec + 1;
    if ($signed(o_prd) !== want || o_vld !== v) begin
      n_err = n_err + 1;
      $display("FAIL dut_%s prd got %0d want %0d, vld got %0b want %0b",
               name, $signed(o_prd), want, o_vld, v);
    end
  endtask

  logic signed [PW-1:0] big;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    i_vld = 1'b1;
    i_op0 = 8'h7F;
    i_op1 = 8'h7F;
    big   = 72'sd49 <<< 60;

    // Pin the model with hand-computed values.
    pin_model(8'h01, 8'h01, 72'sd1, "01x01");
    pin_model(8'h01, 8'h81, -72'sd1, "01x81");
    pin_model(8'h04, 8'h04, 72'sd16, "04x04");
    pin_model(8'h05, 8'h06, 72'sd30, "05x06");
    pin_model(8'h80, 8'h05, 72'sd0, "80x05");
    pin_model(8'h7F, 8'h7F, 72'sh3_1000_0000_0000_0000, "7Fx7F");
    pin_model(8'hFF, 8'h7F, 72'shFCF_0000_0000_0000_000, "FFx7F");

    // Reset holds outputs at zero even with valid operands presented.
    repeat (2) @(posedge clk);
    #1;
    n_vec = n_vec + 1;
    if (o_prd !== '0 || o_vld !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset prd got %0d want 0, vld got %0b want 0", $signed(o_prd), o_vld);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with literal expectations.
    apply_chk(8'h01, 8'h01, 1'b1, 72'sd1, "01x01");
    apply_chk(8'h01, 8'h81, 1'b1, -72'sd1, "01x81");
    apply_chk(8'h04, 8'h04, 1'b1, 72'sd16, "04x04");
    apply_chk(8'h05, 8'h06, 1'b1, 72'sd30, "05x06");
    apply_chk(8'h80, 8'h05, 1'b1, 72'sd0, "80x05");
    apply_chk(8'h00, 8'hFF, 1'b1, 72'sd0, "00xFF");
    apply_chk(8'h7F, 8'h7F, 1'b1, big, "7Fx7F");
    apply_chk(8'hFF, 8'h7F, 1'b1, -big, "FFx7F");
    apply_chk(8'h05, 8'h86, 1'b0, -72'sd30, "novld");
    apply_chk(8'h08, 8'h03, 1'b1, 72'sd24, "08x03");

    // Exhaustive sweep with one reset pulse mid-stream.
    for (int k = 0; k < 65536; k++) begin
      @(negedge clk);
      i_op0 = k[15:8];
      i_op1 = k[7:0];
      i_vld = 1'b1;
      rst   = (k == 30000) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    rst   = 1'b0;
    i_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
